// File: rtl/tnn_feature_framer.sv
// Collects seven raw feature beats, quantizes each to 2 bits and presents the
// assembled sample to the classifier; malformed frames are flagged and dropped.
//
// state   | meaning
// COLLECT | accepting beats, idx selects the destination feature register
// FULL    | complete sample held on input_a..input_g, waiting for m_ready
// DROP    | overlong frame, discarding beats until s_last
module tnn_feature_framer #(
  parameter logic [7:0] TH1 = 8'd64,
  parameter logic [7:0] TH2 = 8'd128,
  parameter logic [7:0] TH3 = 8'd192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [1:0]  input_a,
  output logic [1:0]  input_b,
  output logic [1:0]  input_c,
  output logic [1:0]  input_d,
  output logic [1:0]  input_e,
  output logic [1:0]  input_f,
  output logic [1:0]  input_g,
  output logic        err_frame,
  output logic [15:0] sample_cnt
);

  typedef enum logic [1:0] {COLLECT, FULL, DROP} state_t;

  state_t           state, state_nxt;
  logic [2:0]       idx, idx_nxt;
  logic             err_nxt;
  logic             store;
  logic             xfer;
  logic [1:0]       q;
  logic [6:0][1:0]  feat;
  logic [15:0]      cnt_q;

  always_comb begin
    q = 2'd3;
    if (s_data < TH1)      q = 2'd0;
    else if (s_data < TH2) q = 2'd1;
    else if (s_data < TH3) q = 2'd2;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    err_nxt   = 1'b0;
    store     = 1'b0;
    xfer      = 1'b0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    case (state)
      COLLECT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (idx == 3'd6) begin
            idx_nxt = 3'd0;
            if (s_last) begin
              store     = 1'b1;
              state_nxt = FULL;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = DROP;
            end
          end else if (s_last) begin
            // short frame: the partial values are left behind but never shown
            idx_nxt = 3'd0;
            err_nxt = 1'b1;
          end else begin
            store   = 1'b1;
            idx_nxt = idx + 3'd1;
          end
        end
      end
      FULL: begin
        m_valid = 1'b1;
        if (m_ready) begin
          xfer      = 1'b1;
          state_nxt = COLLECT;
        end
      end
      DROP: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      idx       <= 3'd0;
      err_frame <= 1'b0;
      cnt_q     <= 16'd0;
      feat      <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      err_frame <= err_nxt;
      if (xfer && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      for (int i = 0; i < 7; i++) begin
        if (store && idx == 3'(i)) feat[i] <= q;
      end
    end
  end

  assign input_a    = feat[0];
  assign input_b    = feat[1];
  assign input_c    = feat[2];
  assign input_d    = feat[3];
  assign input_e    = feat[4];
  assign input_f    = feat[5];
  assign input_g    = feat[6];
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_tnn_feature_framer.sv
// Self-checking bench for tnn_feature_framer: directed corner sequences, a
// quantization vector table and randomized frames against a frame-level model.
module tb_tnn_feature_framer;

  localparam logic [7:0] TH1 = 8'd64;
  localparam logic [7:0] TH2 = 8'd128;
  localparam logic [7:0] TH3 = 8'd192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'd0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [1:0]  input_a, input_b, input_c, input_d, input_e, input_f, input_g;
  logic        err_frame;
  logic [15:0] sample_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] q;
  } vec_t;
  vec_t vecs[14];

  tnn_feature_framer #(.TH1(TH1), .TH2(TH2), .TH3(TH3)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .input_a(input_a), .input_b(input_b), .input_c(input_c), .input_d(input_d),
    .input_e(input_e), .input_f(input_f), .input_g(input_g),
    .err_frame(err_frame), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // quantized level = number of thresholds the value reaches
  function automatic logic [1:0] qref(input logic [7:0] d);
    return 2'(int'(d >= TH1) + int'(d >= TH2) + int'(d >= TH3));
  endfunction

  function automatic logic [13:0] exp_outs(input logic [0:6][7:0] fr);
    logic [13:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) r[13-2*i -: 2] = qref(fr[i]);
    return r;
  endfunction

  function automatic logic [13:0] outs();
    return {input_a, input_b, input_c, input_d, input_e, input_f, input_g};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 40) begin
      tick();
      n++;
    end
    if (!s_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL s_ready_timeout: got 0 after %0d cycles, expected 1", n);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [0:6][7:0] fr);
    for (int i = 0; i < 7; i++) send_beat(fr[i], i == 6);
  endtask

  task automatic bump_cnt();
    if (exp_cnt < 65535) exp_cnt++;
  endtask

  task automatic deliver(input string tag, input logic [0:6][7:0] fr);
    m_ready = 1'b0;
    send_frame(fr);
    check({tag, " m_valid"}, m_valid, 1);
    check({tag, " outs"}, outs(), exp_outs(fr));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    bump_cnt();
    check({tag, " m_valid_after"}, m_valid, 0);
    check({tag, " sample_cnt"}, sample_cnt, exp_cnt);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " s_ready"}, s_ready, 1);
    check({tag, " m_valid"}, m_valid, 0);
    check({tag, " err_frame"}, err_frame, 0);
    check({tag, " sample_cnt"}, sample_cnt, 0);
    check({tag, " outs"}, outs(), 0);
  endtask

  initial begin
    logic [0:6][7:0] fr;
    logic [1:0] o[7];
    int len, gap, wait_n;
    logic exp_err;

    vecs = '{'{8'd0, 2'd0}, '{8'd63, 2'd0}, '{8'd64, 2'd1}, '{8'd127, 2'd1},
             '{8'd128, 2'd2}, '{8'd191, 2'd2}, '{8'd192, 2'd3}, '{8'd255, 2'd3},
             '{8'd10, 2'd0}, '{8'd1, 2'd0}, '{8'd100, 2'd1}, '{8'd150, 2'd2},
             '{8'd200, 2'd3}, '{8'd65, 2'd1}};

    #3;
    check_reset_outs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset while the fourth beat is on the bus
    send_beat(8'd100, 1'b0);
    send_beat(8'd200, 1'b0);
    send_beat(8'd150, 1'b0);
    check("mid partial a", input_a, 1);
    s_valid = 1'b1;
    s_data  = 8'd30;
    #2 rst_n = 1'b0;
    #1 check_reset_outs("rst_mid");
    s_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    // reset while a full sample waits
    fr = {8'd250, 8'd250, 8'd250, 8'd250, 8'd250, 8'd250, 8'd250};
    send_frame(fr);
    check("pre_rst_full m_valid", m_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("rst_full");
    m_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    m_ready = 1'b0;
    check("post_rst m_valid", m_valid, 0);
    check("post_rst sample_cnt", sample_cnt, 0);

    // basic sample with m_ready held high
    m_ready = 1'b1;
    fr = {8'd10, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255};
    send_frame(fr);
    check("basic m_valid", m_valid, 1);
    check("basic outs", outs(), 14'b00_01_01_10_10_11_11);
    tick();
    m_ready = 1'b0;
    exp_cnt = 1;
    check("basic m_valid_after", m_valid, 0);
    check("basic sample_cnt", sample_cnt, 1);

    // quantization table, two frames
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 7; i++) send_beat(vecs[f*7+i].data, i == 6);
      o = '{input_a, input_b, input_c, input_d, input_e, input_f, input_g};
      for (int i = 0; i < 7; i++)
        check($sformatf("quant data=%0d", vecs[f*7+i].data), o[i], vecs[f*7+i].q);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      bump_cnt();
      check("table sample_cnt", sample_cnt, exp_cnt);
    end

    // back-pressure: sample held for 5 cycles, upstream stalled
    fr = {8'd70, 8'd5, 8'd230, 8'd140, 8'd64, 8'd63, 8'd192};
    send_frame(fr);
    for (int c = 0; c < 5; c++) begin
      s_valid = 1'b1;
      s_data  = 8'hAA;
      s_last  = 1'b1;
      tick();
      check("hold m_valid", m_valid, 1);
      check("hold s_ready", s_ready, 0);
      check("hold outs", outs(), exp_outs(fr));
      check("hold err_frame", err_frame, 0);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    bump_cnt();
    check("release s_ready", s_ready, 1);
    check("release m_valid", m_valid, 0);
    check("release sample_cnt", sample_cnt, exp_cnt);

    // m_ready with nothing to send
    m_ready = 1'b1;
    repeat (3) tick();
    m_ready = 1'b0;
    check("idle_ready sample_cnt", sample_cnt, exp_cnt);
    check("idle_ready m_valid", m_valid, 0);

    // short frame
    send_beat(8'd1, 1'b0);
    send_beat(8'd2, 1'b0);
    send_beat(8'd3, 1'b1);
    check("short err_frame", err_frame, 1);
    check("short m_valid", m_valid, 0);
    tick();
    check("short err_frame_pulse", err_frame, 0);
    deliver("after_short", {8'd0, 8'd80, 8'd130, 8'd200, 8'd255, 8'd127, 8'd66});

    // overlong frame: nine beats, last on the ninth
    for (int i = 0; i < 9; i++) begin
      send_beat(8'($urandom_range(0, 255)), i == 8);
      if (i == 6) check("long err_frame", err_frame, 1);
      if (i > 6) begin
        check("long err_frame_once", err_frame, 0);
        check("long m_valid", m_valid, 0);
      end
    end
    deliver("after_long", {8'd255, 8'd0, 8'd191, 8'd64, 8'd128, 8'd63, 8'd193});

    // randomized frames against the frame-length model
    for (int k = 0; k < 40; k++) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 7;
      for (int i = 0; i < len; i++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) tick();
        fr[i % 7] = (i < 7) ? 8'($urandom_range(0, 255)) : fr[i % 7];
        send_beat((i < 7) ? fr[i] : 8'($urandom_range(0, 255)), i == len - 1);
        exp_err = (len < 7 && i == len - 1) || (len > 7 && i == 6);
        check("rand err_frame", err_frame, int'(exp_err));
        check("rand m_valid", m_valid, int'(len == 7 && i == 6));
      end
      if (len == 7) begin
        wait_n = $urandom_range(0, 3);
        for (int c = 0; c < wait_n; c++) begin
          tick();
          check("rand hold m_valid", m_valid, 1);
        end
        check("rand outs", outs(), exp_outs(fr));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        bump_cnt();
        check("rand sample_cnt", sample_cnt, exp_cnt);
      end
    end

    // counter saturation
    force dut.cnt_q = 16'hFFFE;
    #1 release dut.cnt_q;
    exp_cnt = 65534;
    check("sat preload", sample_cnt, 65534);
    deliver("sat_first", {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7});
    deliver("sat_hold", {8'd200, 8'd2, 8'd130, 8'd4, 8'd70, 8'd6, 8'd255});
    check("sat final", sample_cnt, 65535);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
